// File: rtl/de_morgan_pkg.sv
// -----------------------------------------------------------------------------
// de_morgan_pkg
// Shared types and constants for the De Morgan logic pipeline.
//   mode_t    : 2-bit operation selector
//   MODE_*    : operation encodings (NOR, NAND, OR, AND)
// -----------------------------------------------------------------------------
package de_morgan_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_NOR  = 2'd0;
  localparam mode_t MODE_NAND = 2'd1;
  localparam mode_t MODE_OR   = 2'd2;
  localparam mode_t MODE_AND  = 2'd3;

endpackage

// File: rtl/de_morgan_pipe_if.sv
// -----------------------------------------------------------------------------
// de_morgan_pipe_if
// Operand/result handshake bundle of the De Morgan pipeline.
//   a, b, mode, inj, in_valid : operand beat from the stimulus source
//   in_ready                  : unit can take an operand beat
//   c, mismatch, out_valid    : result beat towards the sink
//   out_ready                 : sink takes the result beat
// master = stimulus/sink side, slave = the pipeline.
// -----------------------------------------------------------------------------
interface de_morgan_pipe_if
  import de_morgan_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  mode_t            mode;
  logic             inj;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] c;
  logic             mismatch;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output a, b, mode, inj, in_valid, out_ready,
    input  in_ready, c, mismatch, out_valid
  );

  modport slave (
    input  a, b, mode, inj, in_valid, out_ready,
    output in_ready, c, mismatch, out_valid
  );

endinterface

// File: rtl/de_morgan_core.sv
// -----------------------------------------------------------------------------
// de_morgan_core
// Combinational evaluation of one operation in two algebraically equal forms.
//   a, b     : operands
//   mode     : MODE_NOR / MODE_NAND / MODE_OR / MODE_AND
//   inj      : flips bit 0 of the dual form to provoke a mismatch
//   direct   : textbook form, e.g. ~(a|b)
//   dual     : De Morgan form, e.g. ~a & ~b
//   mismatch : the two forms differ in any bit
// -----------------------------------------------------------------------------
module de_morgan_core
  import de_morgan_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  mode_t            mode,
  input  logic             inj,
  output logic [WIDTH-1:0] direct,
  output logic [WIDTH-1:0] dual,
  output logic             mismatch
);

  localparam logic [WIDTH-1:0] BIT0 = WIDTH'(1);

  logic [WIDTH-1:0] dual_raw;

  // NOTE: defaults before the case keep every path assigned, so no latch is inferred.
  always_comb begin
    direct   = '0;
    dual_raw = '0;
    case (mode)
      MODE_NOR:  begin direct = ~(a | b); dual_raw = ~a & ~b;     end
      MODE_NAND: begin direct = ~(a & b); dual_raw = ~a | ~b;     end
      MODE_OR:   begin direct = a | b;    dual_raw = ~(~a & ~b);  end
      MODE_AND:  begin direct = a & b;    dual_raw = ~(~a | ~b);  end
    endcase
  end

  assign dual     = inj ? (dual_raw ^ BIT0) : dual_raw;
  assign mismatch = (direct != dual);

endmodule

// File: rtl/de_morgan_pipe.sv
// -----------------------------------------------------------------------------
// de_morgan_pipe
// Two-stage valid/ready pipeline around de_morgan_core with transfer and
// mismatch statistics.
//   clk     : rising-edge clock
//   rst     : synchronous, active-high reset (wins over clear)
//   bus     : de_morgan_pipe_if.slave operand/result handshake
//   clear   : synchronous clear of vec_cnt, err_cnt, err (pipeline untouched)
//   vec_cnt : results transferred, wraps
//   err_cnt : mismatching results transferred, saturates at all-ones
//   err     : sticky, any mismatching result transferred
// Stage 1 holds the operands, stage 2 the evaluated result.
// -----------------------------------------------------------------------------
module de_morgan_pipe
  import de_morgan_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  de_morgan_pipe_if.slave  bus,
  input  logic             clear,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err
);

  logic             adv1;
  logic             adv2;
  logic             xfer;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  mode_t            s1_mode;
  logic             s1_inj;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_c;
  logic             s2_mis;

  logic [WIDTH-1:0] core_direct;
  logic [WIDTH-1:0] core_dual;
  logic             core_mis;

  // A stage may load when it is empty or its content leaves this cycle.
  assign adv2         = !s2_valid || bus.out_ready;
  assign adv1         = !s1_valid || adv2;
  assign bus.in_ready = adv1;

  // NOTE: state registers use non-blocking assignment so each one samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (adv1) begin
      s1_valid <= bus.in_valid;
    end
  end

  // NOTE: operand registers are not reset; they are only ever read behind s1_valid.
  always_ff @(posedge clk) begin
    if (adv1 && bus.in_valid) begin
      s1_a    <= bus.a;
      s1_b    <= bus.b;
      s1_mode <= bus.mode;
      s1_inj  <= bus.inj;
    end
  end

  de_morgan_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a        (s1_a),
    .b        (s1_b),
    .mode     (s1_mode),
    .inj      (s1_inj),
    .direct   (core_direct),
    .dual     (core_dual),
    .mismatch (core_mis)
  );

  // Result data only moves with a real beat, so c stays on the last result
  // through bubbles as well as stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_c     <= '0;
      s2_mis   <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_c   <= core_direct;
        s2_mis <= core_mis;
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.c         = s2_c;
  assign bus.mismatch  = s2_mis;

  assign xfer = s2_valid && bus.out_ready;

  // clear beats a coincident transfer; rst and clear share the same effect here.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      vec_cnt <= '0;
      err_cnt <= '0;
      err     <= 1'b0;
    end else if (xfer) begin
      vec_cnt <= vec_cnt + CNT_W'(1);
      if (s2_mis) begin
        err <= 1'b1;
        if (err_cnt != '1) begin
          err_cnt <= err_cnt + CNT_W'(1);
        end
      end
    end
  end

  // The core's own mismatch flag must agree with a direct comparison of its forms.
  a_core_consistent : assert property (
    @(posedge clk) disable iff (rst) core_mis == (core_direct != core_dual)
  );

endmodule

// File: tb/tb_de_morgan_pipe.sv
// -----------------------------------------------------------------------------
// tb_de_morgan_pipe
// Two pipelines (CNT_W=16 and CNT_W=2) driven with identical stimulus and
// compared against a beat-queue reference model.
// -----------------------------------------------------------------------------
module tb_de_morgan_pipe;
  import de_morgan_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;
  localparam int CNT_S = 2;
  localparam int unsigned MAX_L = (1 << CNT_W) - 1;
  localparam int unsigned MAX_S = (1 << CNT_S) - 1;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic clear = 1'b0;

  always #5 clk = ~clk;

  de_morgan_pipe_if #(.WIDTH(WIDTH)) bus_m ();
  de_morgan_pipe_if #(.WIDTH(WIDTH)) bus_s ();

  logic [CNT_W-1:0] vec_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             err;
  logic [CNT_S-1:0] vec_cnt_s;
  logic [CNT_S-1:0] err_cnt_s;
  logic             err_s;

  de_morgan_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_m),
    .clear   (clear),
    .vec_cnt (vec_cnt),
    .err_cnt (err_cnt),
    .err     (err)
  );

  de_morgan_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_S)) dut_s (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_s),
    .clear   (clear),
    .vec_cnt (vec_cnt_s),
    .err_cnt (err_cnt_s),
    .err     (err_s)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------------------------------------------------------------------
  // Reference model: every accepted beat is queued with its expected result;
  // it becomes visible one edge after acceptance and leaves on a transfer.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [WIDTH-1:0] c;
    bit               mis;
    int               e_acc;
  } beat_t;

  beat_t       q[$];
  int          edge_cnt = 0;
  int unsigned m_vec    = 0;
  int unsigned m_err    = 0;
  int unsigned m_vec_s  = 0;
  int unsigned m_err_s  = 0;
  bit          m_errf   = 1'b0;
  beat_t       m_bt;
  bit          m_acc;
  bit          m_xfer;

  // Per-bit truth tables indexed by {a_i, b_i}.
  function automatic logic [WIDTH-1:0] ref_op(input mode_t m, input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [3:0]       tt;
    logic [WIDTH-1:0] r;
    case (m)
      MODE_NOR:  tt = 4'b0001;
      MODE_NAND: tt = 4'b0111;
      MODE_OR:   tt = 4'b1110;
      default:   tt = 4'b1000;
    endcase
    for (int i = 0; i < WIDTH; i++) r[i] = tt[{a[i], b[i]}];
    return r;
  endfunction

  function automatic bit exp_valid();
    if (q.size() == 0) return 1'b0;
    return edge_cnt >= q[0].e_acc + 1;
  endfunction

  always @(posedge clk) begin
    m_xfer = exp_valid() && bus_m.out_ready;
    m_acc  = bus_m.in_valid && ((q.size() < 2) || bus_m.out_ready);
    edge_cnt++;
    if (rst) begin
      q.delete();
      m_vec = 0; m_err = 0; m_vec_s = 0; m_err_s = 0; m_errf = 1'b0;
    end else begin
      if (m_xfer) begin
        m_bt    = q.pop_front();
        m_vec   = (m_vec + 1) & MAX_L;
        m_vec_s = (m_vec_s + 1) & MAX_S;
        if (m_bt.mis) begin
          if (m_err < MAX_L) m_err++;
          if (m_err_s < MAX_S) m_err_s++;
          m_errf = 1'b1;
        end
      end
      if (clear) begin
        m_vec = 0; m_err = 0; m_vec_s = 0; m_err_s = 0; m_errf = 1'b0;
      end
      if (m_acc) begin
        m_bt.c     = ref_op(bus_m.mode, bus_m.a, bus_m.b);
        m_bt.mis   = bus_m.inj;
        m_bt.e_acc = edge_cnt;
        q.push_back(m_bt);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (drive only)
  // ---------------------------------------------------------------------------
  task automatic drive(input bit v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input mode_t m, input bit inj);
    bus_m.in_valid = v; bus_m.a = a; bus_m.b = b; bus_m.mode = m; bus_m.inj = inj;
    bus_s.in_valid = v; bus_s.a = a; bus_s.b = b; bus_s.mode = m; bus_s.inj = inj;
  endtask

  task automatic set_ready(input bit r);
    bus_m.out_ready = r;
    bus_s.out_ready = r;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    n_checks++; if (bus_m.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus_m.out_valid); end
    n_checks++; if (bus_m.c !== '0) begin n_fail++; $display("FAIL reset_c: got %h want 00", bus_m.c); end
    n_checks++; if (bus_m.mismatch !== 1'b0) begin n_fail++; $display("FAIL reset_mismatch: got %b want 0", bus_m.mismatch); end
    n_checks++; if (vec_cnt !== '0 || err_cnt !== '0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_stats: got %0d/%0d/%b want 0/0/0", vec_cnt, err_cnt, err); end
    n_checks++; if (vec_cnt_s !== '0 || err_cnt_s !== '0 || err_s !== 1'b0) begin n_fail++; $display("FAIL reset_stats_s: got %0d/%0d/%b want 0/0/0", vec_cnt_s, err_cnt_s, err_s); end
    rst = 1'b0;
    set_ready(1'b0);
    #1;
    n_checks++; if (bus_m.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus_m.in_ready); end
    set_ready(1'b1);
  endtask

  task automatic test_basic();
    drive(1'b1, 8'h0F, 8'h30, MODE_NOR, 1'b0);
    tick();
    drive(1'b0, '0, '0, MODE_NOR, 1'b0);
    n_checks++; if (bus_m.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b want 0", bus_m.out_valid); end
    tick();
    n_checks++; if (bus_m.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency: got %b want 1", bus_m.out_valid); end
    n_checks++; if (bus_m.c !== 8'hC0) begin n_fail++; $display("FAIL basic_c: got %h want c0", bus_m.c); end
    n_checks++; if (bus_m.mismatch !== 1'b0) begin n_fail++; $display("FAIL basic_mismatch: got %b want 0", bus_m.mismatch); end
    tick();
    n_checks++; if (vec_cnt !== 16'd1) begin n_fail++; $display("FAIL basic_vec_cnt: got %0d want 1", vec_cnt); end
    n_checks++; if (bus_m.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drained: got %b want 0", bus_m.out_valid); end
  endtask

  task automatic test_modes();
    logic [WIDTH-1:0] tbl [4] = '{8'h42, 8'hDB, 8'hBD, 8'h24};
    int k = 0;
    int first = -1;
    int last = -1;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int cyc = 0; cyc < 7; cyc++) begin
      if (cyc < 4) drive(1'b1, 8'hA5, 8'h3C, mode_t'(cyc), 1'b0);
      else drive(1'b0, '0, '0, MODE_NOR, 1'b0);
      tick();
      if (bus_m.out_valid === 1'b1) begin
        n_checks++;
        if (k >= 4) begin n_fail++; $display("FAIL modes_extra_beat: got c=%h want no beat", bus_m.c); end
        else if (bus_m.c !== tbl[k]) begin n_fail++; $display("FAIL modes_c%0d: got %h want %h", k, bus_m.c, tbl[k]); end
        if (first < 0) first = cyc;
        last = cyc;
        k++;
      end
    end
    n_checks++; if (k != 4 || last - first != 3) begin n_fail++; $display("FAIL modes_stream: got %0d beats over %0d cycles want 4 over 4", k, last - first + 1); end
    n_checks++; if (vec_cnt !== 16'd4) begin n_fail++; $display("FAIL modes_vec_cnt: got %0d want 4", vec_cnt); end
    n_checks++; if (err_cnt !== '0 || err !== 1'b0) begin n_fail++; $display("FAIL modes_err: got %0d/%b want 0/0", err_cnt, err); end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] ba [3];
    logic [WIDTH-1:0] bb [3];
    mode_t            bm [3];
    logic [WIDTH-1:0] be [3];
    int n_acc = 0;
    for (int i = 0; i < 3; i++) begin
      ba[i] = WIDTH'($urandom);
      bb[i] = WIDTH'($urandom);
      bm[i] = mode_t'($urandom_range(0, 3));
      be[i] = ref_op(bm[i], ba[i], bb[i]);
    end
    set_ready(1'b0);
    for (int cyc = 0; cyc < 5; cyc++) begin
      drive(1'b1, ba[n_acc], bb[n_acc], bm[n_acc], 1'b0);
      #1;
      n_checks++; if (bus_m.in_ready !== (n_acc < 2)) begin n_fail++; $display("FAIL bp_in_ready%0d: got %b want %b", cyc, bus_m.in_ready, n_acc < 2); end
      if (n_acc < 2) n_acc++;
      tick();
      if (cyc >= 1) begin
        n_checks++; if (bus_m.out_valid !== 1'b1 || bus_m.c !== be[0]) begin n_fail++; $display("FAIL bp_stall%0d: got %b/%h want 1/%h", cyc, bus_m.out_valid, bus_m.c, be[0]); end
      end
    end
    set_ready(1'b1);
    #1;
    n_checks++; if (bus_m.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", bus_m.in_ready); end
    tick();
    drive(1'b0, '0, '0, MODE_NOR, 1'b0);
    n_checks++; if (bus_m.out_valid !== 1'b1 || bus_m.c !== be[1]) begin n_fail++; $display("FAIL bp_beat1: got %b/%h want 1/%h", bus_m.out_valid, bus_m.c, be[1]); end
    tick();
    n_checks++; if (bus_m.out_valid !== 1'b1 || bus_m.c !== be[2]) begin n_fail++; $display("FAIL bp_beat2: got %b/%h want 1/%h", bus_m.out_valid, bus_m.c, be[2]); end
    tick();
    n_checks++; if (bus_m.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b want 0", bus_m.out_valid); end
    n_checks++; if (vec_cnt !== CNT_W'(m_vec)) begin n_fail++; $display("FAIL bp_vec_cnt: got %0d want %0d", vec_cnt, m_vec); end
  endtask

  task automatic test_inject();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    drive(1'b1, 8'hFF, 8'hFF, MODE_AND, 1'b1);
    tick();
    drive(1'b0, '0, '0, MODE_NOR, 1'b0);
    tick();
    n_checks++; if (bus_m.c !== 8'hFF || bus_m.mismatch !== 1'b1) begin n_fail++; $display("FAIL inj_result: got %h/%b want ff/1", bus_m.c, bus_m.mismatch); end
    tick();
    n_checks++; if (err_cnt !== 16'd1 || err !== 1'b1) begin n_fail++; $display("FAIL inj_stats: got %0d/%b want 1/1", err_cnt, err); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'hFF, 8'hFF, MODE_AND, 1'b1);
      tick();
    end
    drive(1'b0, '0, '0, MODE_NOR, 1'b0);
    repeat (3) tick();
    n_checks++; if (err_cnt_s !== 2'd3 || vec_cnt_s !== 2'd1 || err_s !== 1'b1) begin n_fail++; $display("FAIL inj_small: got err_cnt %0d vec_cnt %0d err %b want 3/1/1", err_cnt_s, vec_cnt_s, err_s); end
    n_checks++; if (err_cnt !== 16'd5 || vec_cnt !== 16'd5) begin n_fail++; $display("FAIL inj_large: got err_cnt %0d vec_cnt %0d want 5/5", err_cnt, vec_cnt); end
  endtask

  task automatic test_clear_xfer();
    logic [WIDTH-1:0] ya = WIDTH'($urandom);
    logic [WIDTH-1:0] yb = WIDTH'($urandom);
    mode_t            ym = mode_t'($urandom_range(0, 3));
    drive(1'b1, WIDTH'($urandom), WIDTH'($urandom), mode_t'($urandom_range(0, 3)), 1'b1);
    tick();
    drive(1'b1, ya, yb, ym, 1'b0);
    tick();
    drive(1'b0, '0, '0, MODE_NOR, 1'b0);
    n_checks++; if (bus_m.out_valid !== 1'b1 || bus_m.mismatch !== 1'b1) begin n_fail++; $display("FAIL clr_setup: got %b/%b want 1/1", bus_m.out_valid, bus_m.mismatch); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_checks++; if (vec_cnt !== '0 || err_cnt !== '0 || err !== 1'b0) begin n_fail++; $display("FAIL clr_stats: got %0d/%0d/%b want 0/0/0", vec_cnt, err_cnt, err); end
    n_checks++; if (vec_cnt_s !== '0 || err_cnt_s !== '0 || err_s !== 1'b0) begin n_fail++; $display("FAIL clr_stats_s: got %0d/%0d/%b want 0/0/0", vec_cnt_s, err_cnt_s, err_s); end
    n_checks++; if (bus_m.out_valid !== 1'b1 || bus_m.c !== ref_op(ym, ya, yb)) begin n_fail++; $display("FAIL clr_drain: got %b/%h want 1/%h", bus_m.out_valid, bus_m.c, ref_op(ym, ya, yb)); end
    tick();
    n_checks++; if (vec_cnt !== 16'd1 || err !== 1'b0) begin n_fail++; $display("FAIL clr_after: got %0d/%b want 1/0", vec_cnt, err); end
  endtask

  task automatic test_random();
    bit exp_rdy;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 7, WIDTH'($urandom), WIDTH'($urandom),
            mode_t'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
      set_ready($urandom_range(0, 9) < 7);
      clear = ($urandom_range(0, 39) == 0);
      #1;
      exp_rdy = (q.size() < 2) || bus_m.out_ready;
      n_checks++; if (bus_m.in_ready !== exp_rdy || bus_s.in_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_in_ready@%0d: got %b/%b want %b", i, bus_m.in_ready, bus_s.in_ready, exp_rdy); end
      tick();
      n_checks++; if (bus_m.out_valid !== exp_valid()) begin n_fail++; $display("FAIL rnd_out_valid@%0d: got %b want %b", i, bus_m.out_valid, exp_valid()); end
      if (exp_valid()) begin
        n_checks++; if (bus_m.c !== q[0].c || bus_m.mismatch !== q[0].mis) begin n_fail++; $display("FAIL rnd_result@%0d: got %h/%b want %h/%b", i, bus_m.c, bus_m.mismatch, q[0].c, q[0].mis); end
      end
      n_checks++; if (vec_cnt !== CNT_W'(m_vec) || err_cnt !== CNT_W'(m_err) || err !== m_errf) begin n_fail++; $display("FAIL rnd_stats@%0d: got %0d/%0d/%b want %0d/%0d/%b", i, vec_cnt, err_cnt, err, m_vec, m_err, m_errf); end
      n_checks++; if (vec_cnt_s !== CNT_S'(m_vec_s) || err_cnt_s !== CNT_S'(m_err_s) || err_s !== m_errf) begin n_fail++; $display("FAIL rnd_stats_s@%0d: got %0d/%0d/%b want %0d/%0d/%b", i, vec_cnt_s, err_cnt_s, err_s, m_vec_s, m_err_s, m_errf); end
    end
    clear = 1'b0;
    drive(1'b0, '0, '0, MODE_NOR, 1'b0);
    set_ready(1'b1);
    repeat (3) tick();
    n_checks++; if (bus_m.out_valid !== 1'b0 || q.size() != 0) begin n_fail++; $display("FAIL rnd_drain: got %b with %0d queued want 0/0", bus_m.out_valid, q.size()); end
  endtask

  task automatic test_reset_mid();
    set_ready(1'b0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, WIDTH'($urandom), WIDTH'($urandom), mode_t'($urandom_range(0, 3)), 1'b1);
      tick();
    end
    drive(1'b0, '0, '0, MODE_NOR, 1'b0);
    #1;
    n_checks++; if (bus_m.out_valid !== 1'b1 || bus_m.in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_setup: got %b/%b want 1/0", bus_m.out_valid, bus_m.in_ready); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (bus_m.out_valid !== 1'b0 || bus_m.c !== '0 || bus_m.mismatch !== 1'b0) begin n_fail++; $display("FAIL rstmid_out: got %b/%h/%b want 0/00/0", bus_m.out_valid, bus_m.c, bus_m.mismatch); end
    n_checks++; if (vec_cnt !== '0 || err_cnt !== '0 || err !== 1'b0 || vec_cnt_s !== '0 || err_cnt_s !== '0) begin n_fail++; $display("FAIL rstmid_stats: got %0d/%0d/%b want 0/0/0", vec_cnt, err_cnt, err); end
    n_checks++; if (bus_m.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b want 1", bus_m.in_ready); end
    set_ready(1'b1);
    repeat (3) tick();
    n_checks++; if (bus_m.out_valid !== 1'b0 || vec_cnt !== '0) begin n_fail++; $display("FAIL rstmid_ghost: got %b/%0d want 0/0", bus_m.out_valid, vec_cnt); end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    drive(1'b0, '0, '0, MODE_NOR, 1'b0);
    set_ready(1'b1);
    test_reset();
    test_basic();
    test_modes();
    test_backpressure();
    test_inject();
    test_clear_xfer();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish within 1000000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/de_morgan_pipe.md
# de_morgan_pipe

Parametrised, pipelined successor to the single-bit NOR gate. It applies one of four bitwise operations (NOR, NAND, OR, AND) to WIDTH-bit operands, using the direct form and the De Morgan dual form in parallel. It registers the result through a 2-stage valid/ready pipeline and keeps transfer and mismatch statistics. It sits between the lab stimulus source and the result sink/LED display as a self-checking logic unit.

## Interface
- WIDTH, 8, operand and result width (1..64)
- CNT_W, 16, width of both statistics counters
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- mode  in  2  operation: 0 NOR, 1 NAND, 2 OR, 3 AND
- inj  in  1  fault inject: inverts bit 0 of the dual-form result, sampled with the operands
- in_valid  in  1  operands valid
- in_ready  out  1  unit can accept operands
- c  out  WIDTH  result (direct form)
- mismatch  out  1  direct and dual forms differ for this result
- out_valid  out  1  c/mismatch valid
- out_ready  in  1  sink accepts result
- clear  in  1  synchronous clear of statistics
- vec_cnt  out  CNT_W  results transferred, wraps
- err_cnt  out  CNT_W  mismatching results transferred, saturates
- err  out  1  sticky: any mismatch transferred since reset/clear

## Operation
- Direct forms: NOR ~(a|b), NAND ~(a&b), OR a|b, AND a&b.
- Dual forms: NOR ~a&~b, NAND ~a|~b, OR ~(~a&~b), AND ~(~a|~b).
- mismatch = (direct != dual), evaluated over all WIDTH bits.
- Stage 1 registers a, b, mode, inj and valid.
- Stage 2 computes both forms from stage 1 and registers c, mismatch and valid.
- Advance rules:
  - adv2 = !s2_valid | out_ready
  - adv1 = !s1_valid | adv2
  - in_ready = adv1, combinational and with no dependency on in_valid
- A transfer is out_valid & out_ready. On each transfer:
  - vec_cnt +1, wrapping from 2^CNT_W−1 to 0
  - if mismatch: err_cnt +1, holding at 2^CNT_W−1; err set
- clear zeroes vec_cnt, err_cnt and err. It does not touch pipeline contents. When clear coincides with a transfer, clear wins and all three are 0 next cycle.
- While stalled, c, mismatch and out_valid hold stable. A registered beat is never dropped or duplicated.

## Timing
- Reset values: all stage valids 0, out_valid 0, c 0, mismatch 0, vec_cnt 0, err_cnt 0, err 0. in_ready is 1 in the first cycle after reset.
- Latency: operands accepted at edge N appear with out_valid=1 after edge N+1, i.e. 2 cycles, provided out_ready held 1.
- Throughput: 1 result/cycle while out_ready=1.
- Backpressure: with out_ready=0, the pipeline fills in 2 accepted beats, then in_ready=0. in_ready returns to 1 in the same cycle out_ready rises.
- Counters update on the edge that completes the transfer and are visible the next cycle.
- Reset mid-operation: in-flight beats are discarded and all outputs take their reset values on the next edge. rst has priority over clear.

## Structure
- Package de_morgan_pkg holds:
  - mode constants MODE_NOR=0, MODE_NAND=1, MODE_OR=2, MODE_AND=3
  - the 2-bit mode typedef
- Sub-module de_morgan_core, combinational and parametrised by WIDTH:
  - inputs a, b, mode, inj
  - outputs direct, dual, mismatch
  - instantiated between stage 1 and stage 2
- The top level holds the pipeline registers, handshake logic and statistics counters.

## Test plan
- Reset, then WIDTH=8, mode=0, a=0x0F, b=0x30, out_ready=1: c=0xC0, mismatch=0, out_valid 2 cycles after acceptance, vec_cnt=1.
- Stream all four modes with a=0xA5, b=0x3C, one per cycle: c = 0x42, 0xDB, 0xBD, 0x24 on consecutive cycles. vec_cnt=4, err_cnt=0, err=0.
- out_ready=0 with in_valid held:
  - in_ready drops after 2 accepted beats; c stays stable.
  - Raise out_ready: both beats emerge in order, none lost.
- inj=1, mode=3, a=b=0xFF: c=0xFF, mismatch=1, err=1, err_cnt=1. Repeat with CNT_W=2 for 5 injected beats: err_cnt saturates at 3, vec_cnt wraps to 1.
- Assert clear in the same cycle as a mismatching transfer: next cycle vec_cnt=0, err_cnt=0, err=0, and the pipeline contents still drain.
- Assert rst with 2 beats in flight: next cycle out_valid=0, c=0, counters=0, in_ready=1.
